bip_control: RTL and testbench

Multi-cycle control and accumulator unit for the 16-bit accumulator processor. It fetches instructions from a synchronous program memory and decodes them. It drives the operands and add/sub select of the ALU stage directly downstream and writes the ALU result back into the accumulator. It also runs loads and stores against a synchronous data memory and counts execution cycles until halt.

---
 rtl/bip_control.sv | 145 ++++++++++++++
 tb/tb_bip_control.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bip_control.sv
// Multi-cycle FETCH/DECODE/MEM/EXEC control and accumulator unit for the
// 16-bit accumulator processor; drives the downstream ALU and both memories.
module bip_control #(
  parameter int PC_W   = 11,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  output logic [PC_W-1:0]   prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  output logic [PC_W-1:0]   data_addr,
  input  logic [DATA_W-1:0] data_rd,
  output logic [DATA_W-1:0] data_wr,
  output logic              data_wr_en,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic              alu_op,
  input  logic [DATA_W-1:0] alu_result,
  output logic [DATA_W-1:0] acc,
  output logic              halted,
  output logic [15:0]       cycle_count,
  output logic [2:0]        state_dbg
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_MEM    = 3'd2,
    S_EXEC   = 3'd3,
    S_HALT   = 3'd4
  } state_t;

  localparam logic [4:0] OP_HLT  = 5'b00000;
  localparam logic [4:0] OP_STO  = 5'b00001;
  localparam logic [4:0] OP_LD   = 5'b00010;
  localparam logic [4:0] OP_LDI  = 5'b00011;
  localparam logic [4:0] OP_ADD  = 5'b00100;
  localparam logic [4:0] OP_ADDI = 5'b00101;
  localparam logic [4:0] OP_SUB  = 5'b00110;
  localparam logic [4:0] OP_SUBI = 5'b00111;

  state_t            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [15:0]       cnt_q, cnt_d;

  logic [4:0]        opcode;
  logic [4:0]        fetch_opcode;
  logic [DATA_W-1:0] imm;

  assign opcode       = ir_q[DATA_W-1 -: 5];
  assign fetch_opcode = prog_data[DATA_W-1 -: 5];
  assign imm          = {{(DATA_W-PC_W){ir_q[PC_W-1]}}, ir_q[PC_W-1:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      pc_q    <= '0;
      ir_q    <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    acc_d   = acc_q;
    case (state_q)
      S_FETCH: begin
        if (run) state_d = S_DECODE;
      end
      S_DECODE: begin
        ir_d = prog_data;
        if (fetch_opcode == OP_LD || fetch_opcode == OP_ADD || fetch_opcode == OP_SUB)
          state_d = S_MEM;
        else
          state_d = S_EXEC;
      end
      S_MEM: begin
        state_d = S_EXEC;
      end
      S_EXEC: begin
        if (opcode == OP_HLT) begin
          state_d = S_HALT;
        end else begin
          state_d = S_FETCH;
          pc_d    = pc_q + PC_W'(1);
          case (opcode)
            OP_LD:   acc_d = data_rd;
            OP_LDI:  acc_d = imm;
            OP_ADD, OP_ADDI, OP_SUB, OP_SUBI: acc_d = alu_result;
            default: acc_d = acc_q;
          endcase
        end
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  // Stalled FETCH cycles and HALT are not execution cycles.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q != S_HALT && !(state_q == S_FETCH && !run) && cnt_q != 16'hFFFF)
      cnt_d = cnt_q + 16'd1;
  end

  always_comb begin
    alu_b  = '0;
    alu_op = 1'b1;
    case (opcode)
      OP_ADD:  alu_b = data_rd;
      OP_ADDI: alu_b = imm;
      OP_SUB:  begin alu_b = data_rd; alu_op = 1'b0; end
      OP_SUBI: begin alu_b = imm;     alu_op = 1'b0; end
      default: begin alu_b = '0;      alu_op = 1'b1; end
    endcase
  end

  // The strobe decodes straight from state, so an async reset kills it at once.
  assign data_wr_en  = (state_q == S_EXEC) && (opcode == OP_STO);
  assign prog_addr   = pc_q;
  assign data_addr   = ir_q[PC_W-1:0];
  assign data_wr     = acc_q;
  assign alu_a       = acc_q;
  assign acc         = acc_q;
  assign halted      = (state_q == S_HALT);
  assign cycle_count = cnt_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_bip_control.sv
// Directed bench for bip_control with synchronous program/data memory models
// and a combinational add/sub ALU attached.
module tb_bip_control;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        run = 1'b0;
  logic [10:0] prog_addr;
  logic [15:0] prog_data;
  logic [10:0] data_addr;
  logic [15:0] data_rd;
  logic [15:0] data_wr;
  logic        data_wr_en;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic        alu_op;
  logic [15:0] alu_result;
  logic [15:0] acc;
  logic        halted;
  logic [15:0] cycle_count;
  logic [2:0]  state_dbg;

  logic [15:0] prog_mem [0:2047];
  logic [15:0] dmem [0:2047];

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;
  logic [10:0] wr_addr = '0;
  logic [15:0] wr_data = '0;

  bip_control #(.PC_W(11), .DATA_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .run(run),
    .prog_addr(prog_addr), .prog_data(prog_data),
    .data_addr(data_addr), .data_rd(data_rd),
    .data_wr(data_wr), .data_wr_en(data_wr_en),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
    .acc(acc), .halted(halted), .cycle_count(cycle_count), .state_dbg(state_dbg)
  );

  // clock / reset block
  always #5 clk = ~clk;

  // memory and ALU models
  always @(posedge clk) begin
    prog_data <= prog_mem[prog_addr];
    data_rd   <= dmem[data_addr];
    if (data_wr_en) dmem[data_addr] <= data_wr;
  end

  assign alu_result = alu_op ? (alu_a + alu_b) : (alu_a - alu_b);

  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_cnt = 0;
    end else if (data_wr_en) begin
      wr_cnt  = wr_cnt + 1;
      wr_addr = data_addr;
      wr_data = data_wr;
    end
  end

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic fill_prog(input logic [15:0] word);
    for (int i = 0; i < 2048; i++) prog_mem[i] = word;
  endtask

  task automatic start(input logic run_val);
    rst_n = 1'b0;
    run   = run_val;
    tick(2);
    rst_n = 1'b1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_prog_addr"}, 16'(prog_addr), 16'h0000);
    chk({tag, "_data_addr"}, 16'(data_addr), 16'h0000);
    chk({tag, "_wr_en"}, 16'(data_wr_en), 16'h0000);
    chk({tag, "_data_wr"}, data_wr, 16'h0000);
    chk({tag, "_alu_a"}, alu_a, 16'h0000);
    chk({tag, "_alu_b"}, alu_b, 16'h0000);
    chk({tag, "_alu_op"}, 16'(alu_op), 16'h0001);
    chk({tag, "_acc"}, acc, 16'h0000);
    chk({tag, "_halted"}, 16'(halted), 16'h0000);
    chk({tag, "_cycles"}, cycle_count, 16'h0000);
  endtask

  initial begin
    // reset state
    fill_prog(16'h0000);
    rst_n = 1'b0;
    tick(1);
    #1;
    chk_reset_outputs("rst");

    // LDI 5; ADDI 0x7FD; HLT
    prog_mem[0] = 16'h1805;
    prog_mem[1] = 16'h2FFD;
    prog_mem[2] = 16'h0000;
    start(1'b1);
    tick(3);
    chk("t1_ldi_acc", acc, 16'h0005);
    tick(5);
    chk("t1_not_halted_yet", 16'(halted), 16'h0000);
    tick(1);
    chk("t1_acc", acc, 16'h0002);
    chk("t1_halted", 16'(halted), 16'h0001);
    chk("t1_cycles", cycle_count, 16'd9);
    chk("t1_pc", 16'(prog_addr), 16'h0002);
    run = 1'b0;
    tick(4);
    chk("t1_cycles_frozen", cycle_count, 16'd9);
    chk("t1_still_halted", 16'(halted), 16'h0001);

    // LDI 0x3FF; STO 7; LD 7; SUB 7; HLT
    fill_prog(16'h0000);
    prog_mem[0] = 16'h1BFF;
    prog_mem[1] = 16'h0807;
    prog_mem[2] = 16'h1007;
    prog_mem[3] = 16'h3007;
    start(1'b1);
    tick(17);
    chk("t2_halted", 16'(halted), 16'h0001);
    chk("t2_acc", acc, 16'h0000);
    chk("t2_cycles", cycle_count, 16'd17);
    chk("t2_wr_pulses", 16'(wr_cnt), 16'd1);
    chk("t2_wr_addr", 16'(wr_addr), 16'h0007);
    chk("t2_wr_data", wr_data, 16'h03FF);
    tick(3);
    chk("t2_cycles_frozen", cycle_count, 16'd17);
    chk("t2_pc", 16'(prog_addr), 16'h0004);

    // wrap: LDI 0x7FF; ADDI 1 and LDI 0; SUBI 1
    fill_prog(16'h0000);
    prog_mem[0] = 16'h1FFF;
    prog_mem[1] = 16'h2801;
    start(1'b1);
    tick(3);
    chk("t3_ldi_sext", acc, 16'hFFFF);
    tick(6);
    chk("t3_add_wrap", acc, 16'h0000);
    chk("t3_halted", 16'(halted), 16'h0001);
    prog_mem[0] = 16'h1800;
    prog_mem[1] = 16'h3801;
    start(1'b1);
    tick(9);
    chk("t3_sub_wrap", acc, 16'hFFFF);
    chk("t3_sub_cycles", cycle_count, 16'd9);

    // run low after reset, then high
    fill_prog(16'h0000);
    prog_mem[0] = 16'h1805;
    prog_mem[1] = 16'h2FFD;
    start(1'b0);
    tick(10);
    chk("t4_stall_pc", 16'(prog_addr), 16'h0000);
    chk("t4_stall_cycles", cycle_count, 16'h0000);
    chk("t4_stall_state", 16'(state_dbg), 16'h0000);
    run = 1'b1;
    tick(9);
    chk("t4_acc", acc, 16'h0002);
    chk("t4_cycles", cycle_count, 16'd9);
    chk("t4_halted", 16'(halted), 16'h0001);

    // run dropped in DECODE: instruction completes, then stalls
    start(1'b1);
    tick(1);
    run = 1'b0;
    tick(10);
    chk("t4m_acc", acc, 16'h0005);
    chk("t4m_pc", 16'(prog_addr), 16'h0001);
    chk("t4m_cycles", cycle_count, 16'd3);
    chk("t4m_halted", 16'(halted), 16'h0000);
    run = 1'b1;
    tick(6);
    chk("t4m_final_acc", acc, 16'h0002);
    chk("t4m_final_cycles", cycle_count, 16'd9);
    chk("t4m_final_halted", 16'(halted), 16'h0001);

    // LDI 3; STO 9; ADD 9; HLT with resets mid-MEM and mid-STO-EXEC
    fill_prog(16'h0000);
    prog_mem[0] = 16'h1803;
    prog_mem[1] = 16'h0809;
    prog_mem[2] = 16'h2009;
    start(1'b1);
    tick(8);
    chk("t5_in_mem", 16'(state_dbg), 16'h0002);
    #2 rst_n = 1'b0;
    #1;
    chk_reset_outputs("t5_mem_rst");
    @(negedge clk);
    rst_n = 1'b1;
    tick(5);
    chk("t5_in_sto_exec", 16'(state_dbg), 16'h0003);
    chk("t5_sto_strobe", 16'(data_wr_en), 16'h0001);
    #2 rst_n = 1'b0;
    #1;
    chk_reset_outputs("t5_sto_rst");
    @(negedge clk);
    rst_n = 1'b1;
    tick(13);
    chk("t5_acc", acc, 16'h0006);
    chk("t5_cycles", cycle_count, 16'd13);
    chk("t5_halted", 16'(halted), 16'h0001);
    chk("t5_wr_pulses", 16'(wr_cnt), 16'd1);

    // pc wraps through NOPs (opcode 0x1F) back to 0
    fill_prog(16'hFFFF);
    prog_mem[0] = 16'h1923;
    start(1'b1);
    tick(3);
    chk("t6_ldi", acc, 16'h0123);
    tick(3 * 2047);
    chk("t6_pc_wrapped", 16'(prog_addr), 16'h0000);
    chk("t6_nop_acc", acc, 16'h0123);
    chk("t6_cycles", cycle_count, 16'd6144);
    chk("t6_not_halted", 16'(halted), 16'h0000);
    prog_mem[0] = 16'h0000;
    tick(3);
    chk("t6_halted", 16'(halted), 16'h0001);
    chk("t6_final_acc", acc, 16'h0123);
    chk("t6_final_cycles", cycle_count, 16'd6147);

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
